matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream feeder for `matrix_multiplier`. It accepts a serial valid/ready stream of matrix elements: first all of A in row-major order, then all of B in row-major order. It assembles them into shadow registers and, once a full A/B pair is received, transfers the pair to output registers and pulses `valid_o` for one cycle. Its outputs connect directly to the multiplier's `valid_i`, `a_i` and `b_i`. Double buffering lets the next pair load while the issued pair stays stable.

## Interface
- `DATA_WIDTH`, 8, element width; must match the multiplier.
- `A_ROWS`, 2, rows of A.
- `B_COLUMNS`, 2, columns of B.
- `A_COLUMNS_B_ROWS`, 2, shared inner dimension.
- Derived: NA = A_ROWS*A_COLUMNS_B_ROWS, NB = A_COLUMNS_B_ROWS*B_COLUMNS.
- Ports:
  - `clk_i`  in  1  single clock; all logic on the rising edge.
  - `reset_i`  in  1  synchronous, active-high reset.
  - `s_valid_i`  in  1  stream element valid.
  - `s_ready_o`  out  1  loader can accept an element.
  - `s_data_i`  in  DATA_WIDTH  stream element.
  - `s_last_i`  in  1  marks the final B element (used only with `MATRIX_LOADER_LAST_CHECK_EN`).
  - `valid_o`  out  1  one-cycle issue pulse to the multiplier's `valid_i`.
  - `a_o[NA]`  out  DATA_WIDTH each  A elements; index i*A_COLUMNS_B_ROWS+k.
  - `b_o[NB]`  out  DATA_WIDTH each  B elements; index k*B_COLUMNS+j.
  - `busy_o`  out  1  a partial pair is held in the shadow registers.
  - `error_o`  out  1  sticky framing error.

## Operation
- A beat transfers when `s_valid_i && s_ready_o` at a rising edge.
- `s_ready_o` is registered:
  - 0 during the reset cycle.
  - 1 from the first cycle after reset deasserts.
  - Never deasserted otherwise; double buffering removes the need for backpressure.
- State machine: LOAD_A, LOAD_B. Element counter `cnt` is sized $clog2 of max(NA,NB), with a minimum of 1 bit.
  - LOAD_A: each beat writes shadow_a[cnt] and increments `cnt`. On the beat where cnt==NA-1, `cnt` clears and the state goes to LOAD_B.
  - LOAD_B: each beat writes shadow_b[cnt] and increments `cnt`. On the final beat (cnt==NB-1):
    - `a_o` is loaded from shadow_a.
    - `b_o` is loaded from shadow_b, with `s_data_i` written directly into index NB-1.
    - `valid_o` is set to 1 for the next cycle only.
    - `cnt` clears and the state returns to LOAD_A.
- `a_o` and `b_o` hold their values until the next issue. Loading a new pair never disturbs them.
- `busy_o` = (state==LOAD_B) || (cnt!=0).
- No arithmetic is performed; the block is pure data movement with zero width conversion.
- Reset values:
  - `valid_o`=0, `s_ready_o`=0, `error_o`=0, `busy_o`=0.
  - Every element of `a_o`, `b_o`, shadow_a and shadow_b = 0.
  - State=LOAD_A, `cnt`=0.
- Reset mid-load discards the partial pair; no `valid_o` is produced for it.
- Reset in the cycle `valid_o` would assert suppresses that pulse.

## Timing
- Issue latency: `valid_o` is high exactly one cycle after the edge accepting the final B beat. `a_o` and `b_o` update on that same edge.
- The multiplier result is therefore available 2 cycles after the final B beat.
- The first A beat of the next pair may be accepted the cycle immediately after the final B beat.
- Minimum issue period is NA+NB cycles; `valid_o` never asserts in two consecutive cycles unless NA+NB==1.
- Idle cycles (`s_valid_i`=0) freeze the state and `cnt`. Gaps of any length are allowed.

## Configuration
- Macro `MATRIX_LOADER_LAST_CHECK_EN`.
- Undefined:
  - `s_last_i` is ignored.
  - `error_o` is tied to 0.
- Defined: `s_last_i` is checked on every accepted beat.
  - Early last (`s_last_i`=1 on any beat other than the final B beat):
    - The partial pair is discarded.
    - State returns to LOAD_A and `cnt` clears.
    - No `valid_o` is produced.
    - `error_o` is set.
  - Missing last (`s_last_i`=0 on the final B beat):
    - The pair issues normally.
    - `error_o` is set.
  - `error_o` is sticky and is cleared only by `reset_i`.

## Test plan
- Default parameters, stream 1,0,0,1 then 1,2,3,4 (last on the 8th beat), no gaps. Required response:
  - `valid_o` high only in the cycle after beat 8.
  - `a_o`={1,0,0,1}, `b_o`={1,2,3,4}.
  - With the multiplier attached: `c_o`={1,2,3,4} one cycle later.
- Same 8 beats with `s_valid_i` dropping for 3 cycles after beats 2 and 5. Required response:
  - A single `valid_o` pulse one cycle after beat 8.
  - Identical `a_o`/`b_o` to the first case.
- Two pairs back-to-back, 16 beats in 16 cycles (second pair A=2,2,2,2, B=1,1,1,1). Required response:
  - `valid_o` pulses one cycle after beat 8 and one cycle after beat 16.
  - `a_o`/`b_o` hold the first pair throughout beats 9-16, then switch to {2,2,2,2}/{1,1,1,1}.
- Assert `reset_i` for one cycle after beat 6, then send a fresh 8-beat pair. Required response:
  - No `valid_o` from the aborted pair.
  - `a_o`/`b_o` read 0 until the fresh pair issues.
  - `s_ready_o` is 0 in the reset cycle only.
- With `MATRIX_LOADER_LAST_CHECK_EN`: `s_last_i`=1 on beat 6, then a correct 8-beat pair. Required response:
  - No pulse after beat 6.
  - `error_o`=1 from the cycle after beat 6, and it stays 1.
  - The later pair issues correctly.
- With `MATRIX_LOADER_LAST_CHECK_EN`: 8 beats with `s_last_i` never asserted. Required response:
  - `valid_o` pulses one cycle after beat 8.
  - `error_o`=1 in that same cycle.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Serial-to-parallel operand feeder for matrix_multiplier. Accepts a
//   valid/ready stream carrying all of A (row-major) and then all of B
//   (row-major). Elements are collected in shadow registers. When a full
//   A/B pair has arrived it is copied to the output registers and valid_o
//   pulses for one cycle. The output registers are double buffered: the next
//   pair loads into the shadows while the issued pair stays stable.
//
//   Optional feature macro: MATRIX_LOADER_LAST_CHECK_EN
//     When defined, s_last_i is checked on every accepted beat and framing
//     errors set the sticky error_o flag. When undefined, s_last_i is ignored
//     and error_o is tied to 0.
//
// Ports
//   clk_i      in   rising-edge clock
//   reset_i    in   synchronous active-high reset
//   s_valid_i  in   stream element valid
//   s_ready_o  out  loader accepts an element (low only during reset)
//   s_data_i   in   stream element
//   s_last_i   in   marks the final B element (checked only with the macro)
//   valid_o    out  one-cycle issue pulse
//   a_o        out  A elements, index i*A_COLUMNS_B_ROWS+k
//   b_o        out  B elements, index k*B_COLUMNS+j
//   busy_o     out  a partial pair is held in the shadow registers
//   error_o    out  sticky framing error
module matrix_operand_loader #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned A_ROWS           = 2,
  parameter int unsigned B_COLUMNS        = 2,
  parameter int unsigned A_COLUMNS_B_ROWS = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] a_o [A_ROWS*A_COLUMNS_B_ROWS],
  output logic [DATA_WIDTH-1:0] b_o [A_COLUMNS_B_ROWS*B_COLUMNS],
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int unsigned NA   = A_ROWS * A_COLUMNS_B_ROWS;
  localparam int unsigned NB   = A_COLUMNS_B_ROWS * B_COLUMNS;
  localparam int unsigned NMAX = (NA > NB) ? NA : NB;
  localparam int unsigned CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic {
    LOAD_A,
    LOAD_B
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [DATA_WIDTH-1:0] shadow_a [NA];
  logic [DATA_WIDTH-1:0] shadow_b [NB];

  logic beat;
  logic last_a;
  logic last_b;
  logic final_beat;
  logic early_last;
  logic store;
  logic issue;

  assign beat       = s_valid_i && s_ready_o;
  assign last_a     = (cnt == CW'(NA - 1));
  assign last_b     = (cnt == CW'(NB - 1));
  assign final_beat = beat && (state == LOAD_B) && last_b;

`ifdef MATRIX_LOADER_LAST_CHECK_EN
  // A last marker anywhere but on the final B beat aborts the partial pair.
  assign early_last = beat && s_last_i && !final_beat;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_o <= 1'b0;
    end else if (early_last || (final_beat && !s_last_i)) begin
      error_o <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign early_last  = 1'b0;
  assign error_o     = 1'b0;
`endif

  assign store  = beat && !early_last;
  assign issue  = final_beat && !early_last;
  assign busy_o = (state == LOAD_B) || (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= LOAD_A;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (early_last) begin
      state_next = LOAD_A;
      cnt_next   = '0;
    end else if (beat) begin
      unique case (state)
        LOAD_A: begin
          if (last_a) begin
            state_next = LOAD_B;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        LOAD_B: begin
          if (last_b) begin
            state_next = LOAD_A;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = LOAD_A;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Shadow writes use a compare per slot so the element count need not be a
  // power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NA; i++) shadow_a[i] <= '0;
      for (int unsigned i = 0; i < NB; i++) shadow_b[i] <= '0;
    end else if (store) begin
      for (int unsigned i = 0; i < NA; i++) begin
        if ((state == LOAD_A) && (cnt == CW'(i))) shadow_a[i] <= s_data_i;
      end
      for (int unsigned i = 0; i < NB; i++) begin
        if ((state == LOAD_B) && (cnt == CW'(i))) shadow_b[i] <= s_data_i;
      end
    end
  end

  // The final B element bypasses its shadow slot so the pair issues on the
  // same edge that accepts it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_ready_o <= 1'b0;
      valid_o   <= 1'b0;
      for (int unsigned i = 0; i < NA; i++) a_o[i] <= '0;
      for (int unsigned i = 0; i < NB; i++) b_o[i] <= '0;
    end else begin
      s_ready_o <= 1'b1;
      valid_o   <= issue;
      if (issue) begin
        for (int unsigned i = 0; i < NA; i++) a_o[i] <= shadow_a[i];
        for (int unsigned i = 0; i < NB; i++) begin
          b_o[i] <= (i == NB - 1) ? s_data_i : shadow_b[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Testbench for matrix_operand_loader: directed scenarios plus a randomized
// stream, each compared cycle by cycle against a queue-based reference model.
module tb_matrix_operand_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 4;
  localparam int unsigned PW = 4 + DW * (NA + NB);

  logic          clk = 1'b0;
  logic          reset_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          s_last_i;
  logic          valid_o;
  logic [DW-1:0] a_o [NA];
  logic [DW-1:0] b_o [NB];
  logic          busy_o;
  logic          error_o;

  matrix_operand_loader #(
    .DATA_WIDTH      (DW),
    .A_ROWS          (2),
    .B_COLUMNS       (2),
    .A_COLUMNS_B_ROWS(2)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .valid_o  (valid_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .busy_o   (busy_o),
    .error_o  (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: accepted beats are queued; a full pair of NA+NB
  // elements is split into A (first NA) and B (rest) and issued.
  logic [DW-1:0] pend [$];
  logic          exp_valid, exp_busy, exp_ready, exp_err;
  logic [DW-1:0] exp_a [NA];
  logic [DW-1:0] exp_b [NB];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
  } stim_t;
  stim_t stim [$];

`ifdef MATRIX_LOADER_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  task automatic clk_step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    logic acc;
    reset_i   = r;
    s_valid_i = v;
    s_data_i  = d;
    s_last_i  = l;
    acc       = v && exp_ready;
    @(posedge clk);
    cyc++;
    if (r) begin
      pend.delete();
      exp_valid = 1'b0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      for (int i = 0; i < NA; i++) exp_a[i] = '0;
      for (int i = 0; i < NB; i++) exp_b[i] = '0;
    end else begin
      exp_valid = 1'b0;
      exp_ready = 1'b1;
      if (acc) begin
        pend.push_back(d);
        if (pend.size() == NA + NB) begin
          if (LAST_CHECK && !l) exp_err = 1'b1;
          for (int i = 0; i < NA; i++) exp_a[i] = pend[i];
          for (int i = 0; i < NB; i++) exp_b[i] = pend[NA + i];
          exp_valid = 1'b1;
          pend.delete();
        end else if (LAST_CHECK && l) begin
          exp_err = 1'b1;
          pend.delete();
        end
      end
    end
    exp_busy = (pend.size() != 0);
    #1;
  endtask

  function automatic logic [PW-1:0] pack_dut();
    logic [PW-1:0] p;
    p = '0;
    p[PW-1 -: 4] = {valid_o, busy_o, s_ready_o, error_o};
    for (int i = 0; i < NA; i++) p[DW*(NB+i) +: DW] = a_o[i];
    for (int i = 0; i < NB; i++) p[DW*i +: DW] = b_o[i];
    return p;
  endfunction

  function automatic logic [PW-1:0] pack_exp();
    logic [PW-1:0] p;
    p = '0;
    p[PW-1 -: 4] = {exp_valid, exp_busy, exp_ready, exp_err};
    for (int i = 0; i < NA; i++) p[DW*(NB+i) +: DW] = exp_a[i];
    for (int i = 0; i < NB; i++) p[DW*i +: DW] = exp_b[i];
    return p;
  endfunction

  function automatic void add(input logic v, input int d, input logic l, input logic r);
    stim_t s;
    s.v = v; s.d = DW'(d); s.l = l; s.r = r;
    stim.push_back(s);
  endfunction

  function automatic void add_pair(input int e [8], input int last_pos);
    for (int i = 0; i < 8; i++) add(1'b1, e[i], (i == last_pos), 1'b0);
  endfunction

  function automatic void add_start();
    stim.delete();
    add(1'b1, 8'hA5, 1'b1, 1'b1);
    add(1'b0, 0, 1'b0, 1'b0);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      clk_step(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b1);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL reset cyc %0d: got %h want %h", cyc, pack_dut(), pack_exp());
      else n_pass++;
    end
    clk_step(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (s_ready_o !== 1'b1)
      $display("FAIL reset_ready cyc %0d: got %b want 1", cyc, s_ready_o);
    else n_pass++;
  endtask

  task automatic test_basic();
    add_start();
    add_pair('{1, 0, 0, 1, 1, 2, 3, 4}, 7);
    add(1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      clk_step(stim[i].v, stim[i].d, stim[i].l, stim[i].r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL basic step %0d: got %h want %h", i, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    int e [8] = '{1, 0, 0, 1, 1, 2, 3, 4};
    add_start();
    for (int i = 0; i < 8; i++) begin
      add(1'b1, e[i], (i == 7), 1'b0);
      if (i == 1 || i == 4) for (int g = 0; g < 3; g++) add(1'b0, 8'hFF, 1'b0, 1'b0);
    end
    add(1'b0, 0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      clk_step(stim[i].v, stim[i].d, stim[i].l, stim[i].r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL gaps step %0d: got %h want %h", i, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    add_start();
    add_pair('{1, 0, 0, 1, 1, 2, 3, 4}, 7);
    add_pair('{2, 2, 2, 2, 1, 1, 1, 1}, 7);
    add(1'b0, 0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      clk_step(stim[i].v, stim[i].d, stim[i].l, stim[i].r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL back_to_back step %0d: got %h want %h", i, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_load();
    add_start();
    for (int i = 0; i < 6; i++) add(1'b1, $urandom_range(1, 255), 1'b0, 1'b0);
    add(1'b1, 8'h77, 1'b0, 1'b1);
    add_pair('{9, 8, 7, 6, 5, 4, 3, 2}, 7);
    add(1'b0, 0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      clk_step(stim[i].v, stim[i].d, stim[i].l, stim[i].r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL reset_mid step %0d: got %h want %h", i, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  task automatic test_last_marker();
    add_start();
    add_pair('{1, 1, 1, 1, 1, 1, 1, 1}, 5);
    add_pair('{3, 1, 4, 1, 5, 9, 2, 6}, 7);
    add(1'b0, 0, 1'b0, 1'b0);
    add_start();
    add_pair('{1, 0, 0, 1, 1, 2, 3, 4}, 99);
    add(1'b0, 0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      clk_step(stim[i].v, stim[i].d, stim[i].l, stim[i].r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL last_marker step %0d: got %h want %h", i, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic v, l, r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      if (LAST_CHECK)
        l = (pend.size() == NA + NB - 1) ^ ($urandom_range(0, 99) < 3);
      else
        l = $urandom_range(0, 1);
      clk_step(v, DW'($urandom_range(0, 255)), l, r);
      n_checks++;
      if (pack_dut() !== pack_exp())
        $display("FAIL random cyc %0d: got %h want %h", cyc, pack_dut(), pack_exp());
      else n_pass++;
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_busy  = 1'b0;
    exp_err   = 1'b0;
    for (int i = 0; i < NA; i++) exp_a[i] = '0;
    for (int i = 0; i < NB; i++) exp_b[i] = '0;
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_reset_mid_load();
    test_last_marker();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
